// File: rtl/fechadura_pkg.sv
// Shared definitions for the digital lock: digit encoding and verifier states.
package fechadura_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] DIGIT_BLANK = 4'hA;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_LOCKED = 1'b1
    } ver_state_t;

endpackage

// File: rtl/pin_compare.sv
// Full-vector PIN equality, gated by a slot enable.
module pin_compare
    import fechadura_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic [DIGIT_W*N_DIGITS-1:0] a,
    input  logic [DIGIT_W*N_DIGITS-1:0] b,
    input  logic                        en,
    output logic                        match
);

    assign match = en && (a == b);

endmodule

// File: rtl/verificar_senha_multi.sv
// PIN verifier: master PIN plus enabled user slots, consecutive-failure
// counting and a timed lockout. Results are one-cycle registered pulses.
module verificar_senha_multi
    import fechadura_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int N_PINS      = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int PIN_W  = DIGIT_W * N_DIGITS,
    localparam int IDX_W  = (N_PINS > 1) ? $clog2(N_PINS) : 1,
    localparam int FCNT_W = $clog2(MAX_FAILS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pin_valid,
    input  logic [PIN_W-1:0]          pin_digits,
    input  logic [PIN_W-1:0]          master_pin,
    input  logic [PIN_W*N_PINS-1:0]   user_pins,
    input  logic [N_PINS-1:0]         user_en,
    output logic                      senha_fail,
    output logic                      senha_padrao,
    output logic                      senha_master,
    output logic                      senha_locked,
    output logic [IDX_W-1:0]          match_idx,
    output logic                      senha_master_update,
    output logic                      locked,
    output logic [FCNT_W-1:0]         fail_count
);

    localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

    ver_state_t          r_state, w_state_next;
    logic [LCNT_W-1:0]   r_lock_cnt, w_lock_cnt_next;
    logic [FCNT_W-1:0]   r_fail_count, w_fail_count_next;
    logic [FCNT_W-1:0]   w_fail_inc;
    logic                r_fail, w_fail_next;
    logic                r_padrao, w_padrao_next;
    logic                r_master, w_master_next;
    logic                r_locked_p, w_locked_p_next;
    logic [IDX_W-1:0]    r_match_idx, w_match_idx_next;
    logic                r_master_update, w_master_update_next;

    logic                w_blank;
    logic                w_master_match;
    logic [N_PINS-1:0]   w_user_match;
    logic                w_user_hit;
    logic [IDX_W-1:0]    w_user_idx;

    always_comb begin
        w_blank = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (pin_digits[k*DIGIT_W +: DIGIT_W] == DIGIT_BLANK) begin
                w_blank = 1'b1;
            end
        end
    end

    pin_compare #(.N_DIGITS(N_DIGITS)) u_cmp_master (
        .a     (pin_digits),
        .b     (master_pin),
        .en    (1'b1),
        .match (w_master_match)
    );

    for (genvar i = 0; i < N_PINS; i++) begin : g_user
        pin_compare #(.N_DIGITS(N_DIGITS)) u_cmp_user (
            .a     (pin_digits),
            .b     (user_pins[i*PIN_W +: PIN_W]),
            .en    (user_en[i]),
            .match (w_user_match[i])
        );
    end

    // Scan from the top so the lowest matching slot wins.
    always_comb begin
        w_user_hit = 1'b0;
        w_user_idx = '0;
        for (int i = N_PINS - 1; i >= 0; i--) begin
            if (w_user_match[i]) begin
                w_user_hit = 1'b1;
                w_user_idx = IDX_W'(i);
            end
        end
    end

    assign w_fail_inc = r_fail_count + FCNT_W'(1);

    always_comb begin
        w_state_next         = r_state;
        w_lock_cnt_next      = r_lock_cnt;
        w_fail_count_next    = r_fail_count;
        w_fail_next          = 1'b0;
        w_padrao_next        = 1'b0;
        w_master_next        = 1'b0;
        w_locked_p_next      = 1'b0;
        w_match_idx_next     = r_match_idx;
        w_master_update_next = r_master_update;

        case (r_state)
            ST_READY: begin
                if (pin_valid) begin
                    if (!w_blank && w_master_match) begin
                        w_master_next        = 1'b1;
                        w_fail_count_next    = '0;
                        w_master_update_next = 1'b0;
                    end else if (!w_blank && w_user_hit) begin
                        w_padrao_next     = 1'b1;
                        w_fail_count_next = '0;
                        w_match_idx_next  = w_user_idx;
                    end else begin
                        w_fail_next = 1'b1;
                        if (w_fail_inc == FCNT_W'(MAX_FAILS)) begin
                            w_fail_count_next = '0;
                            w_lock_cnt_next   = LCNT_W'(LOCK_CYCLES);
                            w_state_next      = ST_LOCKED;
                        end else begin
                            w_fail_count_next = w_fail_inc;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Attempts during lockout are acknowledged but never compared.
                w_locked_p_next = pin_valid;
                if (r_lock_cnt == LCNT_W'(1)) begin
                    w_lock_cnt_next = '0;
                    w_state_next    = ST_READY;
                end else begin
                    w_lock_cnt_next = r_lock_cnt - LCNT_W'(1);
                end
            end
            default: begin
                w_state_next    = ST_READY;
                w_lock_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_READY;
            r_lock_cnt      <= '0;
            r_fail_count    <= '0;
            r_fail          <= 1'b0;
            r_padrao        <= 1'b0;
            r_master        <= 1'b0;
            r_locked_p      <= 1'b0;
            r_match_idx     <= '0;
            r_master_update <= 1'b1;
        end else begin
            r_state         <= w_state_next;
            r_lock_cnt      <= w_lock_cnt_next;
            r_fail_count    <= w_fail_count_next;
            r_fail          <= w_fail_next;
            r_padrao        <= w_padrao_next;
            r_master        <= w_master_next;
            r_locked_p      <= w_locked_p_next;
            r_match_idx     <= w_match_idx_next;
            r_master_update <= w_master_update_next;
        end
    end

    assign senha_fail          = r_fail;
    assign senha_padrao        = r_padrao;
    assign senha_master        = r_master;
    assign senha_locked        = r_locked_p;
    assign match_idx           = r_match_idx;
    assign senha_master_update = r_master_update;
    assign locked              = (r_state == ST_LOCKED);
    assign fail_count          = r_fail_count;

endmodule

// File: tb/tb_verificar_senha_multi.sv
// Bench for verificar_senha_multi: directed scenarios then random attempts,
// checked against a cycle-level behavioural model of the lock rules.
module tb_verificar_senha_multi;

    localparam int ND = 4;
    localparam int NP = 4;
    localparam int MF = 3;
    localparam int LC = 8;
    localparam int PW = 4 * ND;

    logic              clk;
    logic              rst;
    logic              p_valid;
    logic [PW-1:0]     p_dig;
    logic [PW-1:0]     p_mas;
    logic [PW*NP-1:0]  p_usr;
    logic [NP-1:0]     p_en;
    logic              o_fail, o_pad, o_mas, o_lkp, o_mupd, o_locked;
    logic [1:0]        o_idx;
    logic [1:0]        o_fcnt;

    int total = 0;
    int bad   = 0;

    int m_fails;
    int m_lock_left;
    int m_idx;
    bit m_mupd;
    bit e_fail, e_pad, e_mas, e_lk;

    verificar_senha_multi #(
        .N_DIGITS(ND), .N_PINS(NP), .MAX_FAILS(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pin_valid           (p_valid),
        .pin_digits          (p_dig),
        .master_pin          (p_mas),
        .user_pins           (p_usr),
        .user_en             (p_en),
        .senha_fail          (o_fail),
        .senha_padrao        (o_pad),
        .senha_master        (o_mas),
        .senha_locked        (o_lkp),
        .match_idx           (o_idx),
        .senha_master_update (o_mupd),
        .locked              (o_locked),
        .fail_count          (o_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit same_pin(input logic [PW-1:0] a, input logic [PW-1:0] b);
        for (int k = 0; k < ND; k++) begin
            if (a[4*k +: 4] != b[4*k +: 4]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_fails = 0; m_lock_left = 0; m_idx = 0; m_mupd = 1'b1;
        e_fail = 0; e_pad = 0; e_mas = 0; e_lk = 0;
    endtask

    // One clock of the lock rules, applied to the inputs present before the edge.
    task automatic model_step(input bit v, input logic [PW-1:0] d, input logic [PW-1:0] mp,
                              input logic [PW*NP-1:0] up, input logic [NP-1:0] en);
        bit blank;
        int hit;
        e_fail = 0; e_pad = 0; e_mas = 0; e_lk = 0;
        if (m_lock_left > 0) begin
            if (v) e_lk = 1;
            m_lock_left--;
        end else if (v) begin
            blank = 0;
            for (int k = 0; k < ND; k++) if (d[4*k +: 4] == 4'hA) blank = 1;
            hit = -1;
            for (int i = NP - 1; i >= 0; i--) if (en[i] && same_pin(d, up[PW*i +: PW])) hit = i;
            if (!blank && same_pin(d, mp)) begin
                e_mas = 1; m_fails = 0; m_mupd = 0;
            end else if (!blank && hit >= 0) begin
                e_pad = 1; m_fails = 0; m_idx = hit;
            end else begin
                e_fail = 1;
                m_fails++;
                if (m_fails == MF) begin
                    m_fails = 0;
                    m_lock_left = LC;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fail"},   32'(o_fail),   32'(e_fail));
        chk({tag, ".padrao"}, 32'(o_pad),    32'(e_pad));
        chk({tag, ".master"}, 32'(o_mas),    32'(e_mas));
        chk({tag, ".lk_pls"}, 32'(o_lkp),    32'(e_lk));
        chk({tag, ".locked"}, 32'(o_locked), 32'(m_lock_left > 0));
        chk({tag, ".fcnt"},   32'(o_fcnt),   32'(m_fails));
        chk({tag, ".mupd"},   32'(o_mupd),   32'(m_mupd));
        chk({tag, ".idx"},    32'(o_idx),    32'(m_idx));
    endtask

    task automatic step(input string tag, input bit v, input logic [PW-1:0] d,
                        input logic [PW-1:0] mp, input logic [PW*NP-1:0] up,
                        input logic [NP-1:0] en);
        @(negedge clk);
        p_valid = v; p_dig = d; p_mas = mp; p_usr = up; p_en = en;
        @(posedge clk);
        model_step(v, d, mp, up, en);
        #1;
        check_all(tag);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        p_valid = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [PW*NP-1:0] up_a;
    logic [PW-1:0]    rd, rm;
    logic [PW*NP-1:0] ru;
    logic [NP-1:0]    re;

    initial begin
        rst = 1'b0; p_valid = 1'b0; p_dig = '0; p_mas = '0; p_usr = '0; p_en = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Master match clears the update flag permanently.
        step("t1_master", 1, 16'h4321, 16'h4321, '0, 4'b0000);
        step("t1_after", 0, 16'h0000, 16'h4321, '0, 4'b0000);

        // Duplicate user PIN in slots 2 and 3: lowest enabled slot reported.
        up_a = {16'h1234, 16'h1234, 16'h0000, 16'h0000};
        step("t2_user", 1, 16'h1234, 16'h4321, up_a, 4'b1100);
        step("t2_dis", 1, 16'h1234, 16'h4321, up_a, 4'b0000);
        step("t2_clr", 1, 16'h1234, 16'h4321, up_a, 4'b1000);

        // Blank digit fails even though an enabled slot holds the same code.
        step("t3_blank", 1, 16'h12A4, 16'h4321, {48'h0, 16'h12A4}, 4'b0001);
        step("t3_mfix", 1, 16'h9999, 16'h9999, {48'h0, 16'h9999}, 4'b0001);

        // Three fails lock; master during lockout is ignored.
        reset_dut("t4_rst");
        step("t4_f1", 1, 16'h1111, 16'h4321, up_a, 4'b1100);
        step("t4_f2", 1, 16'h2222, 16'h4321, up_a, 4'b1100);
        step("t4_f3", 1, 16'h3333, 16'h4321, up_a, 4'b1100);
        for (int j = 0; j < LC; j++) begin
            step("t5_lock", (j == 0 || j == LC - 1), 16'h4321, 16'h4321, up_a, 4'b1100);
        end
        step("t5_unlock", 1, 16'h4321, 16'h4321, up_a, 4'b1100);

        // Two fails then a good user PIN clears the count.
        step("t6_f1", 1, 16'h5555, 16'h4321, up_a, 4'b1100);
        step("t6_f2", 1, 16'h6666, 16'h4321, up_a, 4'b1100);
        step("t6_user", 1, 16'h1234, 16'h4321, up_a, 4'b0100);

        // Reset in the middle of a lockout.
        step("t6_l1", 1, 16'h0001, 16'h4321, up_a, 4'b1100);
        step("t6_l2", 1, 16'h0002, 16'h4321, up_a, 4'b1100);
        step("t6_l3", 1, 16'h0003, 16'h4321, up_a, 4'b1100);
        step("t6_idle", 0, 16'h0003, 16'h4321, up_a, 4'b1100);
        reset_dut("t6_rst");
        step("t6_post", 1, 16'h1234, 16'h4321, up_a, 4'b0100);

        // Random attempts biased towards near-matches.
        rm = 16'h2468;
        ru = {16'h1357, 16'h8024, 16'h1357, 16'h0999};
        for (int n = 0; n < 400; n++) begin
            int sel;
            int slot;
            if ($urandom_range(0, 15) == 0) rm = PW'($urandom);
            if ($urandom_range(0, 15) == 0) ru[PW*$urandom_range(0, NP-1) +: PW] = PW'($urandom);
            re = NP'($urandom);
            slot = $urandom_range(0, NP - 1);
            sel = $urandom_range(0, 4);
            case (sel)
                0: rd = rm;
                1: rd = ru[PW*slot +: PW];
                2: rd = PW'($urandom);
                3: begin
                    rd = ru[PW*slot +: PW];
                    rd[4*$urandom_range(0, ND-1) +: 4] = 4'hA;
                end
                default: begin
                    rd = rm;
                    rd[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(11, 15));
                end
            endcase
            step("rnd", ($urandom_range(0, 3) != 0), rd, rm, ru, re);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
